multi_port_register_file: RTL
=============================

Name: multi_port_register_file

Overview:
Parametrised successor to the team's single-write, dual-read register file. It has one write port, ReadPorts combinational read ports and an optional hardwired zero register. A clear sequencer zeroes the array one entry per cycle after reset or on request, and reports Busy while it runs. It sits in the datapath between the decode/control FSM and the ALU operand muxes.

Parameters:
AddressWidth, 6, address bits; depth RegisterHeight = 1 << AddressWidth
RegisterWidth, 16, data bits per entry
ReadPorts, 2, number of independent read ports (1..4)
ZeroRegister, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
Clock  input  1  single system clock, rising edge
nReset  input  1  asynchronous active-low reset
ClearRequest  input  1  level; sampled in IDLE to start a full clear
Busy  output  1  high while the clear sequencer runs
WriteEnable  input  1  write strobe
WriteAddress  input  AddressWidth  write index
WriteData  input  RegisterWidth  write value
WriteError  output  1  one-cycle pulse: write attempted while Busy
ReadAddress  input  ReadPorts x AddressWidth  per-port read index (packed array)
ReadData  output  ReadPorts x RegisterWidth  per-port read value (packed array)

Behaviour:
- Reset (nReset low, asynchronous): State=CLEAR, ClearIndex=0, Busy=1, WriteError=0. The storage array itself has no reset.
- FSM states:
  - CLEAR: each cycle writes 0 to Registers[ClearIndex], then ClearIndex++. When ClearIndex = RegisterHeight-1 is written, next State=IDLE and Busy=0.
  - Clear length is exactly RegisterHeight cycles after reset release; Busy falls on the edge after the last entry is written.
  - IDLE: ClearRequest=1 goes to CLEAR with ClearIndex=0 and Busy=1 on the next edge. ClearRequest is ignored while in CLEAR (no restart, no extension).
- Write, IDLE only: on the rising edge with WriteEnable=1, Registers[WriteAddress] <= WriteData.
  - If ZeroRegister=1 and WriteAddress=0, the write is dropped silently with no error.
- Write while Busy: the write is dropped and WriteError=1 for the following cycle only. If ClearRequest and WriteEnable coincide in IDLE, the write completes on that edge, then the clear starts.
- Reads are combinational with zero latency. ReadData[p] = Registers[ReadAddress[p]].
  - Forced to 0 when Busy=1.
  - Forced to 0 when ZeroRegister=1 and ReadAddress[p]=0.
- Multiple ports may read the same address in the same cycle, and all return the same value.
- Read of the address being written in the same cycle returns the old value, unless the optional bypass is enabled.
- Addresses wrap naturally; no out-of-range condition exists.
- Reset asserted mid-clear or mid-write restarts the clear from index 0. Contents are undefined until the clear completes.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read port whose ReadAddress equals WriteAddress while WriteEnable=1, IDLE, and the write is not dropped returns WriteData combinationally (write-through forwarding).
- Undefined: no forwarding; that read returns the pre-write contents and the new value is visible from the next cycle.

Decomposition:
- Package multi_port_register_file_pkg:
  - state enum typedef {IDLE, CLEAR}
  - default width/depth constants
- One sub-module: register_file_clear_sequencer, containing the FSM, ClearIndex counter, Busy and the clear-write signals. The top level holds the array, the write mux, the read ports and the bypass.

Test Plan:
1. Release reset, WriteEnable=0 -> Busy=1 for exactly 64 cycles; after Busy=0 all 64 entries read 16'h0000 on both ports.
2. IDLE, write 16'hABCD to address 12 and 16'h1234 to address 21 -> ReadAddress={12,21} returns {16'hABCD,16'h1234}; both ports reading 12 return 16'hABCD.
3. Write 16'hFFFF to address 0 with ZeroRegister=1 -> ReadData for address 0 stays 16'h0000 and WriteError stays 0.
4. Pulse ClearRequest in IDLE, then write 16'h5555 to address 5 during the clear -> WriteError pulses for one cycle, Busy lasts 64 cycles, address 5 reads 0 afterwards.
5. Same-cycle write 16'h00AA to address 7 while port 0 reads address 7 -> returns 16'h00AA with REGFILE_BYPASS_EN defined, the old value otherwise; 16'h00AA from the next cycle in both builds.
6. Assert nReset mid-clear at ClearIndex=30 -> Busy stays 1, the clear restarts at 0, and Busy falls 64 cycles after release.

Source files
------------

// File: rtl/multi_port_register_file_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Optional build macro used by the top level: REGFILE_BYPASS_EN (write-through forwarding).
package multi_port_register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned DefaultAddressWidth  = 6;
  localparam int unsigned DefaultRegisterWidth = 16;
  localparam int unsigned DefaultReadPorts     = 2;
  localparam int unsigned DefaultZeroRegister  = 1;

endpackage

// File: rtl/multi_port_register_file_if.sv
// Control, write and read-port bundle between the datapath control and the register file.
interface multi_port_register_file_if
  import multi_port_register_file_pkg::*;
#(
  parameter int unsigned AddressWidth  = DefaultAddressWidth,
  parameter int unsigned RegisterWidth = DefaultRegisterWidth,
  parameter int unsigned ReadPorts     = DefaultReadPorts
);

  logic                                      ClearRequest;
  logic                                      Busy;
  logic                                      WriteEnable;
  logic [AddressWidth-1:0]                   WriteAddress;
  logic [RegisterWidth-1:0]                  WriteData;
  logic                                      WriteError;
  logic [ReadPorts-1:0][AddressWidth-1:0]    ReadAddress;
  logic [ReadPorts-1:0][RegisterWidth-1:0]   ReadData;

  modport master (
    output ClearRequest, WriteEnable, WriteAddress, WriteData, ReadAddress,
    input  Busy, WriteError, ReadData
  );

  modport slave (
    input  ClearRequest, WriteEnable, WriteAddress, WriteData, ReadAddress,
    output Busy, WriteError, ReadData
  );

endinterface

// File: rtl/register_file_clear_sequencer.sv
// Walks a zero write across every entry after reset or on request; flags writes attempted meanwhile.
module register_file_clear_sequencer
  import multi_port_register_file_pkg::*;
#(
  parameter int unsigned AddressWidth = DefaultAddressWidth
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    ClearRequest,
  input  logic                    WriteEnable,
  output logic                    Busy,
  output logic                    WriteError,
  output logic [AddressWidth-1:0] clear_index,
  output logic                    clear_write_c
);

  localparam int unsigned RegisterHeight = 1 << AddressWidth;
  localparam logic [AddressWidth-1:0] LastIndex = AddressWidth'(RegisterHeight - 1);

  state_t state;

  // ClearRequest is only looked at in IDLE, so a running clear is never restarted or stretched.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= CLEAR;
      clear_index <= '0;
      Busy        <= 1'b1;
      WriteError  <= 1'b0;
    end else begin
      WriteError <= WriteEnable && (state == CLEAR);
      case (state)
        CLEAR: begin
          clear_index <= clear_index + AddressWidth'(1);
          if (clear_index == LastIndex) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (ClearRequest) begin
            state       <= CLEAR;
            clear_index <= '0;
            Busy        <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          Busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clear_write_c = (state == CLEAR);

endmodule

// File: rtl/multi_port_register_file.sv
// One-write, N-read register file with optional hardwired zero entry and a self-clearing array.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module multi_port_register_file
  import multi_port_register_file_pkg::*;
#(
  parameter int unsigned AddressWidth  = DefaultAddressWidth,
  parameter int unsigned RegisterWidth = DefaultRegisterWidth,
  parameter int unsigned ReadPorts     = DefaultReadPorts,
  parameter int unsigned ZeroRegister  = DefaultZeroRegister
) (
  input  logic                      Clock,
  input  logic                      nReset,
  multi_port_register_file_if.slave bus
);

  localparam int unsigned RegisterHeight = 1 << AddressWidth;

  logic                                    busy;
  logic                                    write_error;
  logic [AddressWidth-1:0]                 clear_index;
  logic                                    clear_write_c;
  logic                                    write_ok_c;
  logic [RegisterWidth-1:0]                registers [RegisterHeight];
  logic [ReadPorts-1:0][RegisterWidth-1:0] read_data_c;

  register_file_clear_sequencer #(
    .AddressWidth (AddressWidth)
  ) u_clear_sequencer (
    .Clock         (Clock),
    .nReset        (nReset),
    .ClearRequest  (bus.ClearRequest),
    .WriteEnable   (bus.WriteEnable),
    .Busy          (busy),
    .WriteError    (write_error),
    .clear_index   (clear_index),
    .clear_write_c (clear_write_c)
  );

  // A write lands only in IDLE and never on the hardwired zero entry.
  assign write_ok_c = bus.WriteEnable && !busy
                      && !((ZeroRegister != 0) && (bus.WriteAddress == '0));

  // Storage is deliberately unreset; the clear sequencer defines its contents.
  always_ff @(posedge Clock) begin
    if (clear_write_c) begin
      registers[clear_index] <= '0;
    end else if (write_ok_c) begin
      registers[bus.WriteAddress] <= bus.WriteData;
    end
  end

  always_comb begin
    read_data_c = '0;
    for (int p = 0; p < int'(ReadPorts); p++) begin
      if (busy || ((ZeroRegister != 0) && (bus.ReadAddress[p] == '0))) begin
        read_data_c[p] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (write_ok_c && (bus.ReadAddress[p] == bus.WriteAddress)) begin
        read_data_c[p] = bus.WriteData;
`endif
      end else begin
        read_data_c[p] = registers[bus.ReadAddress[p]];
      end
    end
  end

  assign bus.ReadData   = read_data_c;
  assign bus.Busy       = busy;
  assign bus.WriteError = write_error;

endmodule
